// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS instruction-fetch slice.
//   fetch_state_e    : fetch FSM encoding (IDLE, FETCH)
//   RESET_PC_DEFAULT : default PC loaded on reset
//   PC_INC           : sequential fetch stride (one 32-bit word)
package mips_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect target selection for the fetch stage (purely combinational).
// Priority is jr > jump > branch_taken.
//   branch_taken, branch_offset : taken branch and its pre-shifted offset
//   jump, jump_index            : J/JAL and instr[25:0]
//   jr, jr_target               : JR and the rs value
//   if_pc_plus4                 : PC+4 of the instruction sitting in decode
//   redirect                    : any redirect requested this cycle
//   target                      : selected redirect target
module next_pc_sel #(
  parameter int ADDR_W = 32
) (
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic [ADDR_W-1:0] if_pc_plus4,
  output logic              redirect,
  output logic [ADDR_W-1:0] target
);

  // Two's-complement add wraps modulo 2^ADDR_W, which is exactly the
  // required branch behaviour; no overflow is reported.
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;

  assign branch_target = if_pc_plus4 + branch_offset;
  assign jump_target   = {if_pc_plus4[ADDR_W-1:ADDR_W-4], jump_index, 2'b00};
  assign redirect      = jr | jump | branch_taken;

  always_comb begin
    target = branch_target;
    if (jr) begin
      target = jr_target;
    end else if (jump) begin
      target = jump_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, imem req/ready handshake,
// redirect handling and the IF/ID pipeline register.
//   clk, reset          : clock, asynchronous active-high reset
//   stall, flush        : decode hazard hold / IF/ID invalidate
//   branch_*, jump*, jr*: redirects resolved in decode
//   imem_req/addr/ready/rdata : instruction memory handshake
//   if_valid/instr/pc/pc_plus4: IF/ID register contents
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  fetch_state_e      state, state_nx;
  logic              armed;
  logic [ADDR_W-1:0] pc;
  logic              pending;
  logic [ADDR_W-1:0] pending_target;
  logic              outstanding;
  logic              skid_valid;
  logic [31:0]       skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              complete;
  logic              in_flight;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .if_pc_plus4   (if_pc_plus4),
    .redirect      (redirect),
    .target        (target)
  );

  // A raised request is held until accepted even if stall rises
  // (outstanding). A new request waits while the skid still holds a word,
  // so skid drain and a fresh completion never compete for IF/ID.
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    case (state)
      IDLE:  if (armed) state_nx = FETCH;
      FETCH: imem_req = outstanding | (~stall & ~skid_valid);
      default: state_nx = IDLE;
    endcase
  end

  assign imem_addr = pc;
  assign complete  = imem_req & imem_ready;
  assign in_flight = imem_req & ~imem_ready;

  // armed delays leaving IDLE by one edge, so the first fetch launches on
  // the 2nd edge after release and the first instruction lands on the 3rd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      pc          <= RESET_PC;
      pending     <= 1'b0;
      outstanding <= 1'b0;
      skid_valid  <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else begin
      state       <= state_nx;
      armed       <= 1'b1;
      outstanding <= in_flight;

      // A redirect that coincides with a completion discards that word and
      // jumps straight away; only a still-waiting request defers it.
      if (redirect) begin
        if (in_flight) begin
          pending <= 1'b1;
        end else begin
          pc      <= target;
          pending <= 1'b0;
        end
      end else if (complete) begin
        if (pending) begin
          pc      <= pending_target;
          pending <= 1'b0;
        end else begin
          pc <= pc + ADDR_W'(PC_INC);
        end
      end

      if (redirect) begin
        skid_valid <= 1'b0;
      end else if (complete & ~pending & stall) begin
        skid_valid <= 1'b1;
      end else if (~stall) begin
        skid_valid <= 1'b0;
      end

      if (flush | redirect) begin
        if_valid <= 1'b0;
      end else if (stall) begin
        if_valid <= if_valid;
      end else if (skid_valid) begin
        if_valid    <= 1'b1;
        if_instr    <= skid_instr;
        if_pc       <= skid_pc;
        if_pc_plus4 <= skid_pc + ADDR_W'(PC_INC);
      end else if (complete & ~pending) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_rdata;
        if_pc       <= pc;
        if_pc_plus4 <= pc + ADDR_W'(PC_INC);
      end else begin
        if_valid <= 1'b0;
      end
    end
  end

  // Data-only registers: qualified by pending / skid_valid, so no reset.
  always_ff @(posedge clk) begin
    if (redirect & in_flight) begin
      pending_target <= target;
    end
    if (~redirect & complete & ~pending & stall) begin
      skid_instr <= imem_rdata;
      skid_pc    <= pc;
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage of the MIPS datapath: holds the program counter, issues word fetches to instruction memory over a req/ready handshake, and presents the fetched instruction to decode through an IF/ID register.
- Directly consumes the branch-offset shifter's output: branch target = PC+4 + (sign-extended immediate << 2), so `branch_offset` arrives already shifted.
- Also resolves jump, jump-register, stall and flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; must be 32 for jump concatenation.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode hazard; hold the IF/ID register and PC, issue no new fetch.
- flush  in  1  invalidate the IF/ID register (if_valid<=0) at the next edge.
- branch_taken  in  1  taken branch resolved in decode (one-cycle pulse).
- branch_offset  in  32  sign-extended immediate already shifted left by 2.
- jump  in  1  J/JAL in decode (pulse).
- jump_index  in  26  instr[25:0].
- jr  in  1  JR in decode (pulse).
- jr_target  in  32  rs value.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  memory accepts and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_req & imem_ready.
- if_valid  out  1  IF/ID holds a live instruction.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  32  IF/ID PC.
- if_pc_plus4  out  32  IF/ID PC+4.

Behaviour:
- Reset (async):
  - pc=RESET_PC.
  - FSM=IDLE.
  - pending=0.
  - if_valid=0; if_instr, if_pc and if_pc_plus4 = 0.
  - imem_req=0.
- FSM IDLE: one cycle after reset release, imem_req=0; then go to FETCH.
- FSM FETCH:
  - imem_req=1 unless stall=1.
  - imem_addr=pc.
  - A request already raised is not withdrawn by stall; it completes, and its data is held in a skid register until stall drops.
- Completion (imem_req & imem_ready):
  - If pending=0 and stall=0: IF/ID <= {1, imem_rdata, pc, pc+4}; pc<=pc+4.
  - If pending=1: the returned word is discarded (if_valid<=0); pc<=pending_target; pending<=0.
- Redirect target selection, priority jr > jump > branch_taken:
  - jr: target = jr_target.
  - jump: target = {if_pc_plus4[31:28], jump_index, 2'b00}.
  - branch: target = if_pc_plus4 + branch_offset, modulo 2^32 (wrap-around, no overflow flag).
- Redirect timing:
  - If no request is outstanding in the redirect cycle: pc<=target directly.
  - Otherwise: pending<=1, pending_target<=target.
  - A redirect always sets if_valid<=0 at the next edge (delay slot not supported).
- A second redirect while pending=1 overwrites pending_target.
- flush and a redirect in the same cycle: both take effect.
- flush with stall: flush wins; if_valid<=0.
- Misaligned targets (bits[1:0]≠0) are passed through unmodified; alignment checking is out of scope.
- Latency:
  - imem_ready tied high gives one instruction per cycle.
  - First if_valid=1 appears at the 3rd rising edge after reset release.

Decomposition:
- Shared mips_pkg: FSM state encoding (IDLE, FETCH), RESET_PC default, the constant 4.
- One natural sub-module: next_pc_sel (combinational priority mux and branch adder); the FSM and registers stay in fetch_pc_unit.

Test Plan:
- Sequential fetch: reset, imem_ready=1, rdata=addr → if_pc = 0,4,8,12 on consecutive cycles; if_pc_plus4 = if_pc+4.
- Branch: if_pc_plus4=0x0000_0010, branch_offset=0xFFFF_FFF0, branch_taken pulse → next fetch addr 0x0000_0000; if_valid=0 for one cycle.
- Jump: if_pc_plus4=0x4000_0008, jump_index=0x0000_100 → imem_addr=0x4000_0400.
- Redirect during wait: imem_ready=0 for 3 cycles, jr_target=0x0000_0080 pulsed in cycle 1 → imem_addr stays unchanged until ready; that word is discarded; next addr=0x80.
- Stall: stall=1 for 2 cycles with pc=0x20 → IF/ID and pc frozen, imem_req=0; resume fetching 0x20.
- Mid-operation reset: assert reset with imem_req=1 → outputs return to reset values immediately; pc=RESET_PC.
